// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared encodings for the DRAM responder
// Purpose: FSM state and op encodings plus the display address shared with
//          the processor top. No ports.
package dram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Byte address of the memory-mapped display, shared with the processor.
  localparam logic [31:0] DISPLAY_ADDR = 32'hFFFF_0000;

endpackage

// File: rtl/dram_responder_ram.sv
// rtl/dram_responder_ram.sv - single-clock simple-dual-port 32-bit word RAM
// Purpose: backing store for the responder, one synchronous write port and
//          one synchronous read port so it maps onto block RAM.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o only changes when this is high
//   raddr_i  in   read word index
//   rdata_o  out  registered read data
module dram_responder_ram
  import dram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads; the top relies on this
  // to keep read data stable until the next read completes.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - memory-side responder for the dram_* req/fin interface
// Purpose: serves one read or write at a time from an internal word RAM with
//          a programmable response latency.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   dram_wr_req   in   write request level, held until fin
//   dram_wr_addr  in   write byte address, bits [1:0] ignored
//   dram_wr_data  in   write data
//   dram_wr_fin   out  one-cycle pulse, write committed
//   dram_rd_req   in   read request level, held until fin
//   dram_rd_addr  in   read byte address, bits [1:0] ignored
//   dram_rd_data  out  read data, valid at fin and held until next read
//   dram_rd_fin   out  one-cycle pulse, read data valid
//   busy          out  high whenever the FSM is not IDLE
//   err           out  sticky out-of-range flag
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          LATENCY    = 2,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dram_wr_req,
  input  logic [31:0] dram_wr_addr,
  input  logic [31:0] dram_wr_data,
  output logic        dram_wr_fin,
  input  logic        dram_rd_req,
  input  logic [31:0] dram_rd_addr,
  output logic [31:0] dram_rd_data,
  output logic        dram_rd_fin,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e                state_q;
  logic [3:0]            cnt_q;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  inr_q, inr_d;
  logic                  wr_fin_q, rd_fin_q, busy_q, err_q;
  logic                  rd_ok_q;

  logic                  accept;
  logic                  enter_resp;
  logic [31:0]           acc_addr;
  logic [32:0]           diff;
  logic [31:0]           ram_rdata;
  logic                  unused_bits;

  // The _d values are the transaction being served: freshly sampled inputs
  // on the accept edge, the latched copy otherwise. This lets LATENCY=0 go
  // straight from IDLE to RESP using the request inputs directly.
  always_comb begin
    accept   = (state_q == IDLE) && (dram_wr_req || dram_rd_req);
    acc_addr = dram_wr_req ? dram_wr_addr : dram_rd_addr;
    // 33-bit subtraction: bit 32 set means the address is below BASE_ADDR.
    diff     = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    if (accept) begin
      op_d    = dram_wr_req ? OP_WR : OP_RD;
      idx_d   = diff[ADDR_WIDTH+1:2];
      wdata_d = dram_wr_data;
      inr_d   = !diff[32] && ((diff[31:2] >> ADDR_WIDTH) == 30'd0);
    end else begin
      op_d    = op_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      inr_d   = inr_q;
    end
    enter_resp = !reset &&
                 ((accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd1)));
  end

  assign unused_bits = ^diff[1:0];

  dram_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we_i    (enter_resp && (op_d == OP_WR) && inr_d),
    .waddr_i (idx_d),
    .wdata_i (wdata_d),
    .re_i    (enter_resp && (op_d == OP_RD) && inr_d),
    .raddr_i (idx_d),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= OP_RD;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      inr_q    <= 1'b0;
      wr_fin_q <= 1'b0;
      rd_fin_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      wr_fin_q <= 1'b0;
      rd_fin_q <= 1'b0;
      op_q     <= op_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      inr_q    <= inr_d;
      if (enter_resp) begin
        state_q <= RESP;
        busy_q  <= 1'b1;
        if (op_d == OP_WR) begin
          wr_fin_q <= 1'b1;
        end else begin
          rd_fin_q <= 1'b1;
          // Out-of-range reads leave the RAM output alone and force zero.
          rd_ok_q  <= inr_d;
        end
        if (!inr_d) begin
          err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= WAIT;
              cnt_q   <= LAT;
              busy_q  <= 1'b1;
            end
          end
          WAIT:    cnt_q   <= cnt_q - 4'd1;
          RESP:    state_q <= RELEASE;
          RELEASE: begin
            // Hold here until the served request drops so it is not re-served.
            if (!((op_q == OP_WR) ? dram_wr_req : dram_rd_req)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dram_wr_fin  = wr_fin_q;
  assign dram_rd_fin  = rd_fin_q;
  assign dram_rd_data = rd_ok_q ? ram_rdata : 32'h0;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - self-checking bench for dram_responder
module tb_dram_responder;

  // Per-instance configuration, instance 0 in the low field.
  localparam logic [127:0] BASE_T = {32'h100, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0]  LAT_T  = {8'd0, 8'd3, 8'd2, 8'd2};
  localparam logic [31:0]  AW_T   = {8'd14, 8'd14, 8'd4, 8'd14};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [4];
  logic        wr_req  [4];
  logic        rd_req  [4];
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  logic [31:0] rd_addr [4];
  logic [31:0] rd_data [4];
  logic        wr_fin  [4];
  logic        rd_fin  [4];
  logic        busy    [4];
  logic        err     [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dram_responder #(
      .ADDR_WIDTH (int'(AW_T[g*8 +: 8])),
      .BASE_ADDR  (BASE_T[g*32 +: 32]),
      .LATENCY    (int'(LAT_T[g*8 +: 8])),
      .INIT_FILE  ("")
    ) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .dram_wr_req  (wr_req[g]),
      .dram_wr_addr (wr_addr[g]),
      .dram_wr_data (wr_data[g]),
      .dram_wr_fin  (wr_fin[g]),
      .dram_rd_req  (rd_req[g]),
      .dram_rd_addr (rd_addr[g]),
      .dram_rd_data (rd_data[g]),
      .dram_rd_fin  (rd_fin[g]),
      .busy         (busy[g]),
      .err          (err[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [int];
  bit          err_m [4];

  function automatic int lat_of(input int d);
    return int'(LAT_T[d*8 +: 8]);
  endfunction

  function automatic bit in_range(input int d, input logic [31:0] a);
    longint base, la, words;
    base  = longint'(BASE_T[d*32 +: 32]);
    la    = longint'(a);
    words = longint'(1) << AW_T[d*8 +: 8];
    if (la < base) return 1'b0;
    return ((la - base) / 4) < words;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    longint base;
    base = longint'(BASE_T[d*32 +: 32]);
    return d * 65536 + int'((longint'(a) - base) / 4);
  endfunction

  task automatic model(input int d, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] data, output logic [31:0] exp_rd, output bit exp_err);
    exp_rd = 32'h0;
    if (!in_range(d, a)) err_m[d] = 1'b1;
    else if (is_wr) mem_m[key(d, a)] = data;
    else if (mem_m.exists(key(d, a))) exp_rd = mem_m[key(d, a)];
    exp_err = err_m[d];
  endtask

  // ---------------- transaction driver/checker ----------------
  task automatic txn(input int d, input bit is_wr, input logic [31:0] a, input logic [31:0] data,
                     input int hold, input logic [31:0] exp_rd, input bit exp_err, input string nm);
    int lat;
    lat = lat_of(d);
    @(negedge clk);
    if (is_wr) begin
      wr_addr[d] = a; wr_data[d] = data; wr_req[d] = 1'b1;
    end else begin
      rd_addr[d] = a; rd_req[d] = 1'b1;
    end
    for (int k = 1; k <= lat + 1 + hold; k++) begin
      @(negedge clk);
      chk($sformatf("%s fin_at_edge%0d", nm, k), is_wr ? wr_fin[d] : rd_fin[d], 32'(k == lat + 1));
      chk($sformatf("%s busy_at_edge%0d", nm, k), busy[d], 1);
      if (k == lat + 1) begin
        if (!is_wr) chk({nm, " rd_data"}, rd_data[d], exp_rd);
        chk({nm, " err"}, err[d], exp_err);
      end
    end
    wr_req[d] = 1'b0;
    rd_req[d] = 1'b0;
    @(negedge clk);
    chk({nm, " fin_low_after"}, is_wr ? wr_fin[d] : rd_fin[d], 0);
    @(negedge clk);
    chk({nm, " busy_released"}, busy[d], 0);
    if (!is_wr) chk({nm, " rd_data_held"}, rd_data[d], exp_rd);
  endtask

  task automatic run(input int d, input bit is_wr, input logic [31:0] a,
                     input logic [31:0] data, input int hold, input string nm);
    logic [31:0] e_rd;
    bit          e_err;
    model(d, is_wr, a, data, e_rd, e_err);
    txn(d, is_wr, a, data, hold, e_rd, e_err, nm);
  endtask

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd;
    bit          e_err;
    bit          got;

    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; wr_req[d] = 1'b0; rd_req[d] = 1'b0;
      wr_addr[d] = 32'h0; wr_data[d] = 32'h0; rd_addr[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset wr_fin%0d", d), wr_fin[d], 0);
      chk($sformatf("reset rd_fin%0d", d), rd_fin[d], 0);
      chk($sformatf("reset rd_data%0d", d), rd_data[d], 0);
      chk($sformatf("reset busy%0d", d), busy[d], 0);
      chk($sformatf("reset err%0d", d), err[d], 0);
      rst[d] = 1'b0;
    end

    // Known contents for the small-RAM instance.
    for (int i = 0; i < 16; i++) run(1, 1'b1, 32'(4 * i), 32'(i) * 32'h0101_0101, 0, "prefill1");

    vecs.push_back('{0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0,   32'hA5A5A5A5, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 32'h40,  32'h11111111, 32'h0,        1'b1});
    vecs.push_back('{1, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b1});
    vecs.push_back('{1, 1'b0, 32'h40,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1, 1'b1, 32'h3F,  32'h00000077, 32'h0,        1'b1});
    vecs.push_back('{1, 1'b0, 32'h3C,  32'h0,        32'h00000077, 1'b1});
    vecs.push_back('{2, 1'b1, 32'h10,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{3, 1'b1, 32'h100, 32'h0BADF00D, 32'h0,        1'b0});
    vecs.push_back('{3, 1'b0, 32'h103, 32'h0,        32'h0BADF00D, 1'b0});
    vecs.push_back('{3, 1'b0, 32'hFC,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{3, 1'b0, 32'h101, 32'h0,        32'h0BADF00D, 1'b1});
    foreach (vecs[i]) begin
      model(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, e_rd, e_err);
      txn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, 0,
          vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Held read request: one fin only, busy until req drops.
    txn(0, 1'b0, 32'h100, 32'h0, 5, 32'hDEADBEEF, 1'b0, "held_rd");

    // Reset clears the sticky error.
    @(negedge clk); rst[1] = 1'b1;
    @(negedge clk); rst[1] = 1'b0;
    chk("err_cleared_by_reset", err[1], 0);
    err_m[1] = 1'b0;

    // Simultaneous write and read: write first, read after write released.
    @(negedge clk);
    wr_addr[0] = 32'h200; wr_data[0] = 32'h12345678; rd_addr[0] = 32'h200;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1;
    model(0, 1'b1, 32'h200, 32'h12345678, e_rd, e_err);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("simul wr_fin_edge%0d", k), wr_fin[0], 32'(k == 3));
      chk($sformatf("simul rd_fin_edge%0d", k), rd_fin[0], 0);
    end
    wr_req[0] = 1'b0;
    got = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (rd_fin[0]) begin
        chk("simul rd_fin_edge", 32'(j), 32'd5);
        chk("simul rd_data", rd_data[0], 32'h12345678);
        got = 1'b1;
        break;
      end
    end
    chk("simul rd_fin_seen", got, 1);
    rd_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("simul busy_released", busy[0], 0);

    // Reset on the second WAIT edge discards the write.
    @(negedge clk);
    wr_addr[2] = 32'h10; wr_data[2] = 32'hCAFEF00D; wr_req[2] = 1'b1;
    @(negedge clk);
    chk("rstwr busy_after_accept", busy[2], 1);
    @(negedge clk);
    rst[2] = 1'b1; wr_req[2] = 1'b0;
    @(negedge clk);
    chk("rstwr wr_fin", wr_fin[2], 0);
    chk("rstwr busy", busy[2], 0);
    rst[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstwr no_late_fin", wr_fin[2], 0);
    end
    txn(2, 1'b0, 32'h10, 32'h0, 0, 32'h11223344, 1'b0, "rstwr old_value");

    // Known contents for the random pool on instances 0 and 3.
    for (int i = 0; i < 8; i++) begin
      run(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 0, "prefill0");
      run(3, 1'b1, 32'h100 + 32'(4 * i), $urandom, 0, "prefill3");
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 2));
      if (d == 2) d = 3;
      if (d == 1) a = 32'($urandom_range(0, 32'h5F));
      else if ($urandom_range(0, 7) == 0) a = (d == 0) ? 32'h10000 : 32'hF8;
      else a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      run(d, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)),
          $sformatf("rand%0d_d%0d_%h", n, d, a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
